// File: rtl/count_to_ones.sv
// count_to_ones: on a start request, emits cnt single-cycle pulses spaced by
// GAP idle cycles, builds an LSB-first thermometer code of the emitted ones,
// and finishes with a one-cycle done strobe. Every output comes straight from
// a flop, so start and cnt never reach an output combinationally.
module count_to_ones #(
    parameter int GAP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] cnt,
    output logic       busy,
    output logic       pulse,
    output logic [6:0] therm,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT  = 2'd1,
        SPACE = 2'd2,
        FIN   = 2'd3
    } state_t;

    // SPACE counts down from GAP-1 to 0, so it lasts exactly GAP cycles.
    localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    state_t     state_q, state_d;
    logic [2:0] remaining_q, remaining_d;
    logic [3:0] gap_q, gap_d;
    logic [6:0] therm_q, therm_d;
    logic       busy_q, busy_d;
    logic       pulse_q, pulse_d;
    logic       done_q, done_d;

    // Next-state and datapath decode; outputs are pre-decoded from the next state.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        gap_d       = gap_q;
        therm_d     = therm_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    remaining_d = cnt;
                    therm_d     = 7'd0;
                    gap_d       = 4'd0;
                    state_d     = (cnt != 3'd0) ? EMIT : FIN;
                end else begin
                    state_d = IDLE;
                end
            end
            EMIT: begin
                therm_d = {therm_q[5:0], 1'b1};
                if (remaining_q <= 3'd1) begin
                    // Last one emitted; saturate so remaining never wraps.
                    remaining_d = 3'd0;
                    state_d     = FIN;
                end else begin
                    remaining_d = remaining_q - 3'd1;
                    if (GAP == 0) begin
                        state_d = EMIT;
                    end else begin
                        gap_d   = GAP_LOAD;
                        state_d = SPACE;
                    end
                end
            end
            SPACE: begin
                if (gap_q == 4'd0) begin
                    state_d = EMIT;
                end else begin
                    gap_d   = gap_q - 4'd1;
                    state_d = SPACE;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d  = (state_d != IDLE);
        pulse_d = (state_d == EMIT);
        done_d  = (state_d == FIN);
    end

    // State, counters and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= 3'd0;
            gap_q       <= 4'd0;
            therm_q     <= 7'd0;
            busy_q      <= 1'b0;
            pulse_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            gap_q       <= gap_d;
            therm_q     <= therm_d;
            busy_q      <= busy_d;
            pulse_q     <= pulse_d;
            done_q      <= done_d;
        end
    end

    assign busy  = busy_q;
    assign pulse = pulse_q;
    assign therm = therm_q;
    assign done  = done_q;

endmodule

// File: tb/tb_count_to_ones.sv
// Bench for count_to_ones: one instance with GAP=0 and one with GAP=1 share
// clock and reset. A timeline model pushes the expected per-cycle outputs to a
// scoreboard when a request is driven; each cycle pops and compares.
module tb_count_to_ones;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_g0, start_g1;
    logic [2:0] cnt_g0, cnt_g1;
    logic       busy_g0, busy_g1, pulse_g0, pulse_g1, done_g0, done_g1;
    logic [6:0] therm_g0, therm_g1;

    count_to_ones #(.GAP(0)) u_dut_g0 (
        .clk(clk), .rst(rst), .start(start_g0), .cnt(cnt_g0),
        .busy(busy_g0), .pulse(pulse_g0), .therm(therm_g0), .done(done_g0)
    );

    count_to_ones #(.GAP(1)) u_dut_g1 (
        .clk(clk), .rst(rst), .start(start_g1), .cnt(cnt_g1),
        .busy(busy_g1), .pulse(pulse_g1), .therm(therm_g1), .done(done_g1)
    );

    typedef struct {
        int         sel;        // 0 -> GAP=0 instance, 1 -> GAP=1 instance
        int         n;
        int         inj_cyc;    // cycle after which start is re-asserted (0 = none)
        int         inj_cnt;
        bit         fin_start;  // hold start high across the FIN edge
        int         exp_pulses;
        logic [6:0] exp_therm;
        int         exp_fin;
    } vec_t;

    vec_t       tbl[7];
    logic [9:0] sbq[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] rec(input logic p, input logic b, input logic d,
                                       input logic [6:0] t);
        return {p, b, d, t};
    endfunction

    function automatic int pop7(input logic [6:0] v);
        int c = 0;
        for (int i = 0; i < 7; i++) c += int'(v[i]);
        return c;
    endfunction

    task automatic set_in(input int sel, input logic s, input logic [2:0] c);
        if (sel == 0) begin
            start_g0 = s;
            cnt_g0   = c;
        end else begin
            start_g1 = s;
            cnt_g1   = c;
        end
    endtask

    task automatic sample(input int sel, output logic p, output logic b,
                          output logic d, output logic [6:0] t);
        if (sel == 0) begin
            p = pulse_g0; b = busy_g0; d = done_g0; t = therm_g0;
        end else begin
            p = pulse_g1; b = busy_g1; d = done_g1; t = therm_g1;
        end
    endtask

    // Expected timeline: EMIT cycles, GAP idle cycles between them, then FIN.
    task automatic push_model(input int gap, input int n);
        logic [6:0] cur = 7'd0;
        if (n == 0) begin
            sbq.push_back(rec(1'b0, 1'b1, 1'b1, 7'd0));
        end else begin
            for (int i = 1; i <= n; i++) begin
                sbq.push_back(rec(1'b1, 1'b1, 1'b0, cur));
                cur = {cur[5:0], 1'b1};
                if (i < n) begin
                    for (int g = 0; g < gap; g++) sbq.push_back(rec(1'b0, 1'b1, 1'b0, cur));
                end
            end
            sbq.push_back(rec(1'b0, 1'b1, 1'b1, cur));
        end
    endtask

    // Issue one request (caller sits just after a falling edge) and track it to idle.
    task automatic run_req(input int sel, input int n, input int inj_cyc, input int inj_cnt,
                           input bit fin_start, input int exp_pulses,
                           input logic [6:0] exp_therm, input int exp_fin, input string tag);
        logic       p, b, d;
        logic [6:0] t, fin_t;
        logic [9:0] e;
        int         cyc, pulses, fin_cyc;
        bit         got_done;
        sbq.delete();
        push_model(sel, n);
        set_in(sel, 1'b1, 3'(n));
        @(posedge clk);
        #1;
        set_in(sel, 1'b0, 3'($urandom_range(0, 7)));
        cyc = 0; pulses = 0; fin_cyc = 0; fin_t = 7'd0; got_done = 1'b0;
        while (!got_done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            sample(sel, p, b, d, t);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk($sformatf("%s cyc%0d {pulse,busy,done,therm}", tag, cyc),
                    int'(rec(p, b, d, t)), int'(e));
            end else begin
                chk($sformatf("%s cyc%0d busy past expected FIN", tag, cyc), int'(b), 0);
            end
            if (p) pulses++;
            if (d) begin
                got_done = 1'b1;
                fin_cyc  = cyc;
                fin_t    = t;
            end
            if (cyc == inj_cyc)        set_in(sel, 1'b1, 3'(inj_cnt));
            else if (d && fin_start)   set_in(sel, 1'b1, 3'd4);
            else                       set_in(sel, 1'b0, 3'($urandom_range(0, 7)));
        end
        chk($sformatf("%s done seen before timeout", tag), int'(got_done), 1);
        chk($sformatf("%s pulse count", tag), pulses, exp_pulses);
        chk($sformatf("%s FIN cycle", tag), fin_cyc, exp_fin);
        chk($sformatf("%s therm in FIN", tag), int'(fin_t), int'(exp_therm));
        chk($sformatf("%s ones-count round trip", tag), pop7(fin_t), n);
        chk($sformatf("%s scoreboard drained", tag), sbq.size(), 0);
        @(negedge clk);
        sample(sel, p, b, d, t);
        chk($sformatf("%s idle after FIN", tag), int'(rec(p, b, d, t)),
            int'(rec(1'b0, 1'b0, 1'b0, exp_therm)));
        set_in(sel, 1'b0, 3'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       p, b, d;
        logic [6:0] t;
        int         pulses;

        tbl[0] = '{1, 3, 0, 0, 1'b0, 3, 7'b0000111, 6};
        tbl[1] = '{1, 0, 0, 0, 1'b0, 0, 7'b0000000, 1};
        tbl[2] = '{0, 7, 0, 0, 1'b0, 7, 7'b1111111, 8};
        tbl[3] = '{1, 5, 2, 2, 1'b0, 5, 7'b0011111, 10};
        tbl[4] = '{0, 5, 2, 2, 1'b1, 5, 7'b0011111, 6};
        tbl[5] = '{1, 7, 0, 0, 1'b1, 7, 7'b1111111, 14};
        tbl[6] = '{0, 1, 0, 0, 1'b1, 1, 7'b0000001, 2};

        // Reset state, with start asserted while reset is held.
        rst = 1'b1;
        set_in(0, 1'b0, 3'd0);
        set_in(1, 1'b1, 3'd3);
        #2;
        sample(0, p, b, d, t);
        chk("reset g0 outputs", int'(rec(p, b, d, t)), 0);
        sample(1, p, b, d, t);
        chk("reset g1 outputs", int'(rec(p, b, d, t)), 0);
        repeat (2) @(negedge clk);
        sample(1, p, b, d, t);
        chk("start ignored in reset", int'(rec(p, b, d, t)), 0);
        rst = 1'b0;
        set_in(1, 1'b0, 3'd0);

        for (int i = 0; i < 7; i++) begin
            run_req(tbl[i].sel, tbl[i].n, tbl[i].inj_cyc, tbl[i].inj_cnt, tbl[i].fin_start,
                    tbl[i].exp_pulses, tbl[i].exp_therm, tbl[i].exp_fin,
                    $sformatf("vec%0d", i));
        end

        // Back-to-back sweep on GAP=1: each start lands in the IDLE cycle after FIN.
        for (int n = 0; n < 8; n++) begin
            run_req(1, n, 0, 0, 1'b0, n, 7'((1 << n) - 1), (n == 0) ? 1 : 2 * n,
                    $sformatf("sweep%0d", n));
        end

        // Mid-request reset: cnt=6 on GAP=1, reset after the second pulse.
        set_in(1, 1'b1, 3'd6);
        @(posedge clk);
        #1;
        set_in(1, 1'b0, 3'd2);
        pulses = 0;
        for (int c = 0; c < 20 && pulses < 2; c++) begin
            @(negedge clk);
            sample(1, p, b, d, t);
            if (p) pulses++;
        end
        chk("rst-abort pulses before reset", pulses, 2);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        sample(1, p, b, d, t);
        chk("rst-abort outputs cleared immediately", int'(rec(p, b, d, t)), 0);
        set_in(1, 1'b1, 3'd7);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            sample(1, p, b, d, t);
            chk($sformatf("rst-abort held cyc%0d no done", c), int'(rec(p, b, d, t)), 0);
        end
        rst = 1'b0;
        run_req(1, 1, 0, 0, 1'b0, 1, 7'b0000001, 2, "post-reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/count_to_ones.md
COUNT_TO_ONES -- requirements
Module: count_to_ones

Interface
REQ-001 Parameter: GAP, default 1, idle cycles between consecutive pulses (legal 0..15).
REQ-002 Reset is asynchronous and active-high; the block has one clock.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 cnt  input  3  number of ones to emit, 0..7.
REQ-007 busy  output  1  high while a request is in progress.
REQ-008 pulse  output  1  one-cycle strobe per emitted one.
REQ-009 therm  output  7  thermometer accumulation of emitted ones, LSB-first fill.
REQ-010 done  output  1  one-cycle completion strobe.

Function
REQ-011 The FSM shall have exactly four states: IDLE, EMIT, SPACE, FIN.
REQ-012 All outputs shall be decoded from registers only, with no combinational path from start or cnt to any output.
REQ-013 IDLE with start=1 at an edge: capture cnt into a 3-bit remaining register and clear therm to 0.
REQ-014 On that same IDLE edge, the next state is EMIT if cnt!=0 and FIN if cnt==0.
REQ-015 IDLE with start=0: hold state and hold therm, so the last result stays visible.
REQ-016 pulse=1 exactly in EMIT cycles.
REQ-017 At the edge leaving EMIT: therm <= {therm[5:0],1'b1} and remaining decrements by 1.
REQ-018 Next state after EMIT: FIN if remaining was 1, otherwise SPACE (or EMIT directly when GAP=0).
REQ-019 SPACE lasts exactly GAP cycles via a 4-bit gap counter, then goes to EMIT.
REQ-020 FIN lasts one cycle with done=1, then goes to IDLE.
REQ-021 busy=1 in EMIT, SPACE and FIN; busy=0 in IDLE.
REQ-022 start while busy=1 shall be ignored, with no queuing and no effect on the current request.
REQ-023 cnt changes while busy=1 shall be ignored; only the captured value is used.
REQ-024 For cnt=N>=1, pulse count is exactly N.
REQ-025 For cnt=N>=1, latency from the start edge to FIN is N + (N-1)*GAP cycles.
REQ-026 For cnt=N>=1, therm in FIN equals (2^N)-1.
REQ-027 For cnt=0: no pulse, FIN in the first cycle after the start edge, therm=0.
REQ-028 remaining shall never wrap below 0; EMIT is never entered with remaining=0.
REQ-029 Round-trip property: feeding therm into the team's 7-input ones counter in FIN returns the captured cnt.
REQ-030 start=1 in the FIN cycle shall be ignored; a new request is accepted only from IDLE, the cycle after FIN.

Reset
REQ-031 rst=1 shall force state=IDLE, busy=0, pulse=0, done=0, therm=7'b0000000, remaining=0 and the gap counter=0 immediately, without waiting for clk.
REQ-032 Reset mid-request shall abort it, with no done strobe.
REQ-033 After rst is released, the first rising edge shall evaluate as IDLE.
REQ-034 While rst=1, start shall be ignored.

Verification
REQ-035 The bench shall run GAP=1, cnt=3, start pulsed one cycle: pulse high in cycles 1, 3, 5; therm steps 0000001, 0000011, 0000111; FIN with done=1 in cycle 6; busy high cycles 1-6.
REQ-036 The bench shall run cnt=0: done=1 in cycle 1, no pulse, therm=0000000, busy high for one cycle.
REQ-037 The bench shall run GAP=0, cnt=7: pulse high in cycles 1-7, therm=1111111, done=1 in cycle 8; round-trip ones counter output = 3'b111.
REQ-038 The bench shall run cnt=5 with start re-asserted at cycle 2 (cnt=2): it is ignored, exactly 5 pulses, therm=0011111.
REQ-039 The bench shall run cnt=6, GAP=1, with rst asserted mid-cycle after the 2nd pulse: all outputs zero immediately, no done; after release, cnt=1 yields one pulse, therm=0000001.
REQ-040 The bench shall sweep cnt=0..7 back-to-back, each start issued in the IDLE cycle after FIN: popcount(therm) in FIN equals cnt for all 8 values.
